// File: rtl/key_debounce_if.sv
// key_debounce_if: key inputs and debounced code outputs of key_debounce
//   key_n    raw active-low buttons, bit0=S1 .. bit3=S4
//   key_val  one-cycle key code pulse, 0 = none, 1..4 = S1..S4
//   key_held high while a debounced press is held
//   master drives key_n (board/bench), slave is the debouncer
interface key_debounce_if;
    logic [3:0] key_n;
    logic [2:0] key_val;
    logic       key_held;
    modport master (output key_n, input key_val, key_held);
    modport slave  (input key_n, output key_val, key_held);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: four bouncy active-low buttons to single-cycle key codes
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  key_debounce_if.slave: key_n in, key_val/key_held out
//   KEY_REPEAT_EN (macro) enables auto-repeat pulses while a key is held
module key_debounce #(
    parameter int DEB_MAX       = 999_999,
    parameter int CNT_W         = 26,
    parameter int REPEAT_DELAY  = 24_999_999,
    parameter int REPEAT_PERIOD = 9_999_999
) (
    input logic           clk,
    input logic           rst,
    key_debounce_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, PRESS_DEB = 2'd1, HELD = 2'd2, REL_DEB = 2'd3;

    logic [3:0]       key_m, key_s, pressed;
    logic [1:0]       state, idx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       code, pri;
    logic             fire, down, cnt_done, rep_fire;

    assign pressed  = ~key_s;
    assign pri      = pressed[0] ? 3'd1 : pressed[1] ? 3'd2 : pressed[2] ? 3'd3 : 3'd4;
    // code 1..4 maps to bit 0..3; code 4 wraps to 3 in two bits
    assign idx      = code[1:0] - 2'd1;
    assign down     = pressed[idx];
    assign cnt_done = cnt == CNT_W'(DEB_MAX);
    // HELD and REL_DEB are the two states with bit 1 set
    assign bus.key_held = state[1];

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            {key_s, key_m} <= '1;
        else
            {key_s, key_m} <= {key_m, bus.key_n};

`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rcnt;
    logic             rep;

    // rep marks that the initial delay has elapsed and the shorter period applies
    assign rep_fire = state == HELD && down &&
                      rcnt == (rep ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY));

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else if (state != HELD || !down) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else if (rep_fire) begin
            rcnt <= '0;
            rep  <= 1'b1;
        end else begin
            rcnt <= rcnt + CNT_W'(1);
        end
`else
    logic unused_repeat;
    assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rep_fire = 1'b0;
`endif

    // fire is staged one cycle so key_val is a registered copy of the latched code
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            code        <= 3'd0;
            fire        <= 1'b0;
            bus.key_val <= 3'd0;
        end else begin
            fire        <= rep_fire;
            bus.key_val <= fire ? code : 3'd0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|pressed) begin
                        code  <= pri;
                        state <= PRESS_DEB;
                    end
                end
                PRESS_DEB:
                    if (!down) begin
                        cnt   <= '0;
                        code  <= 3'd0;
                        state <= IDLE;
                    end else if (cnt_done) begin
                        fire  <= 1'b1;
                        cnt   <= '0;
                        state <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                HELD:
                    if (!down) begin
                        cnt   <= '0;
                        state <= REL_DEB;
                    end
                REL_DEB:
                    if (down) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt_done) begin
                        cnt   <= '0;
                        code  <= 3'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with a pulse scoreboard
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;
    exp_t exp_q[$];

    key_debounce_if bus();

    key_debounce #(
        .DEB_MAX(9),
        .CNT_W(26),
        .REPEAT_DELAY(29),
        .REPEAT_PERIOD(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle key_val must equal the scheduled pulse, or 0 when none is due.
    always @(negedge clk) begin
        logic [2:0] want;
        exp_t e;
        want = 3'd0;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            want = e.val;
        end
        checks++;
        assert (bus.key_val === want)
        else begin
            errors++;
            $error("FAIL key_val cyc=%0d got=%0d exp=%0d", cyc, bus.key_val, want);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int d, input logic [2:0] v);
        exp_q.push_back('{cyc + d, v});
    endtask

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    initial begin
        bus.key_n = 4'hF;
        rst = 1'b0;
        step(3);
        @(negedge clk);
        chk("reset_val", int'(bus.key_val), 0);
        chk("reset_held", int'(bus.key_held), 0);
        step(1);
        rst = 1'b1;
        step(2);

        // 1: clean S3 press, pulse 14 cycles after the fall
        bus.key_n = 4'b1011;
        expect_pulse(14, 3'd3);
`ifdef KEY_REPEAT_EN
        expect_pulse(44, 3'd3);
`endif
        step(50);
        bus.key_n = 4'hF;
        step(12);
        @(negedge clk);
        chk("t1_held_rel_deb", int'(bus.key_held), 1);
        step(1);
        @(negedge clk);
        chk("t1_held_idle", int'(bus.key_held), 0);
        step(5);
        chk("t1_done", exp_q.size(), 0);

        // 2: S1 glitch then real press
        bus.key_n = 4'b1110;
        step(5);
        bus.key_n = 4'hF;
        step(3);
        bus.key_n = 4'b1110;
        expect_pulse(14, 3'd1);
        step(30);
        bus.key_n = 4'hF;
        step(16);
        @(negedge clk);
        chk("t2_held", int'(bus.key_held), 0);
        chk("t2_done", exp_q.size(), 0);

        // 3: S2 and S4 together, S2 wins; S4 release ignored
        bus.key_n = 4'b0101;
        expect_pulse(14, 3'd2);
        step(25);
        bus.key_n = 4'b1101;
        step(5);
        @(negedge clk);
        chk("t3_held", int'(bus.key_held), 1);
        bus.key_n = 4'hF;
        step(16);
        @(negedge clk);
        chk("t3_idle", int'(bus.key_held), 0);
        chk("t3_done", exp_q.size(), 0);

        // 4: S4 held through S2 release is a new press, then S4 release bounce
        bus.key_n = 4'b0101;
        expect_pulse(14, 3'd2);
        step(20);
        bus.key_n = 4'b0111;
        expect_pulse(25, 3'd4);
        step(35);
        bus.key_n = 4'hF;
        step(4);
        bus.key_n = 4'b0111;
        step(3);
        bus.key_n = 4'hF;
        step(12);
        @(negedge clk);
        chk("t4_held_rel_deb", int'(bus.key_held), 1);
        step(1);
        @(negedge clk);
        chk("t4_idle", int'(bus.key_held), 0);
        step(5);
        chk("t4_done", exp_q.size(), 0);

        // 5: reset during PRESS_DEB and during HELD
        bus.key_n = 4'b1110;
        step(6);
        rst = 1'b0;
        #1;
        chk("t5_rst_val", int'(bus.key_val), 0);
        chk("t5_rst_held", int'(bus.key_held), 0);
        step(1);
        rst = 1'b1;
        expect_pulse(14, 3'd1);
        step(20);
        @(negedge clk);
        chk("t5_held", int'(bus.key_held), 1);
        rst = 1'b0;
        #1;
        chk("t5_rst2_held", int'(bus.key_held), 0);
        step(1);
        rst = 1'b1;
        expect_pulse(14, 3'd1);
        step(20);
        bus.key_n = 4'hF;
        step(16);
        @(negedge clk);
        chk("t5_idle", int'(bus.key_held), 0);
        chk("t5_done", exp_q.size(), 0);

        // 6: long S3 hold, repeats only with KEY_REPEAT_EN
        bus.key_n = 4'b1011;
        expect_pulse(14, 3'd3);
`ifdef KEY_REPEAT_EN
        for (int i = 0; i < 5; i++) expect_pulse(44 + 10 * i, 3'd3);
`endif
        step(88);
        bus.key_n = 4'hF;
        step(16);
        @(negedge clk);
        chk("t6_done", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
